// File: rtl/sar_pkg.sv
// Shared definitions for the SAR result averaging stage: default widths,
// FSM state encoding and the averaging-exponent clamp.
package sar_pkg;

  localparam int SAR_DW     = 8;
  localparam int SAR_MAXLOG = 4;

  typedef enum logic {IDLE, ACC} sar_avg_state_t;

  // Requested exponents above the supported maximum fall back to the maximum.
  function automatic logic [2:0] clamp_log2(input logic [2:0] req,
                                            input logic [2:0] maxlog);
    if (req > maxlog) return maxlog;
    return req;
  endfunction

endpackage

// File: rtl/sar_avg_outreg.sv
// One-deep valid/ready output register for averaged words, with a sticky
// overrun flag raised when a new word arrives while the held one is stalled.
module sar_avg_outreg
  import sar_pkg::*;
#(
  parameter int DW = SAR_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [DW-1:0] load_data,
  input  logic          out_ready,
  input  logic          clr_ovr,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  output logic          overrun
);

  // Handshake: a word moves when out_valid && out_ready in the same cycle;
  // while out_valid is high and out_ready low, out_data is held unchanged.
  logic can_load;
  logic drop;

  assign can_load = !out_valid || out_ready;
  assign drop     = load && !can_load;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      overrun   <= 1'b0;
    end else begin
      if (load && can_load) begin
        out_valid <= 1'b1;
        out_data  <= load_data;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      // A drop in the same cycle as a clear keeps the flag set.
      if (drop)         overrun <= 1'b1;
      else if (clr_ovr) overrun <= 1'b0;
    end
  end

endmodule

// File: rtl/sar_result_avg.sv
// Averages 2^L consecutive SAR conversion results into one rounded, saturated
// DW-bit word and hands it to a valid/ready output register.
module sar_result_avg
  import sar_pkg::*;
#(
  parameter int DW     = SAR_DW,
  parameter int MAXLOG = SAR_MAXLOG
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [2:0]    avg_log2,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          overrun,
  input  logic          clr_ovr
);

  localparam int AW = DW + MAXLOG;
  localparam logic [MAXLOG:0] CNT_ONE = {{MAXLOG{1'b0}}, 1'b1};
  localparam logic [AW:0]     SUM_ONE = {{AW{1'b0}}, 1'b1};
  localparam logic [2:0]      MAXLOG_3 = 3'(MAXLOG);

  sar_avg_state_t state, state_next;
  logic [AW-1:0]  acc, acc_next;
  logic [MAXLOG:0] cnt, cnt_next, cnt_last;
  logic [2:0]     l_q, l_next;
  logic           win_done;

  logic [AW:0]    sum, bias, rounded, shifted;
  logic [DW-1:0]  res;

  assign cnt_last = (CNT_ONE << l_q) - CNT_ONE;

  // Rounding adds half an LSB of the result (nothing when L=0).
  always_comb begin
    sum     = {1'b0, acc} + {{(MAXLOG + 1){1'b0}}, in_data};
    bias    = (SUM_ONE << l_q) >> 1;
    rounded = sum + bias;
    shifted = rounded >> l_q;
    res     = (|shifted[AW:DW]) ? {DW{1'b1}} : shifted[DW-1:0];
  end

  always_comb begin
    state_next = state;
    acc_next   = acc;
    cnt_next   = cnt;
    l_next     = l_q;
    win_done   = 1'b0;
    case (state)
      IDLE: begin
        if (en) begin
          state_next = ACC;
          l_next     = clamp_log2(avg_log2, MAXLOG_3);
          acc_next   = '0;
          cnt_next   = '0;
        end
      end
      ACC: begin
        if (!en) begin
          state_next = IDLE;
          acc_next   = '0;
          cnt_next   = '0;
        end else if (in_valid) begin
          if (cnt == cnt_last) begin
            win_done = 1'b1;
            acc_next = '0;
            cnt_next = '0;
            l_next   = clamp_log2(avg_log2, MAXLOG_3);
          end else begin
            acc_next = sum[AW-1:0];
            cnt_next = cnt + CNT_ONE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
      l_q   <= '0;
    end else begin
      state <= state_next;
      acc   <= acc_next;
      cnt   <= cnt_next;
      l_q   <= l_next;
    end
  end

  sar_avg_outreg #(.DW(DW)) u_outreg (
    .clk       (clk),
    .rst       (rst),
    .load      (win_done),
    .load_data (res),
    .out_ready (out_ready),
    .clr_ovr   (clr_ovr),
    .out_valid (out_valid),
    .out_data  (out_data),
    .overrun   (overrun)
  );

endmodule

// File: tb/tb_sar_result_avg.sv
// Directed bench for sar_result_avg: hand-computed averages, backpressure,
// abort, reconfiguration and reset, with a transfer scoreboard.
module tb_sar_result_avg;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic [2:0]    avg_log2;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          overrun;
  logic          clr_ovr;

  int checks = 0;
  int failures = 0;
  logic [DW-1:0] exp_q[$];

  sar_result_avg dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .avg_log2  (avg_log2),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .overrun   (overrun),
    .clr_ovr   (clr_ovr)
  );

  // Clock and reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Driver tasks: inputs change 1 time unit after the active edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [DW-1:0] d);
    in_valid = 1'b1;
    in_data  = d;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic start(input logic [2:0] l);
    en = 1'b0;
    tick();
    avg_log2 = l;
    en = 1'b1;
    tick();
  endtask

  // Scoreboard: every completed transfer must match the next expected word.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) check("xfer_unexpected", 32'(exp_q.size()), 1);
      else check("xfer", 32'(out_data), 32'(exp_q.pop_front()));
    end
  end

  initial begin
    rst = 1'b1; en = 1'b0; avg_log2 = 3'd0; in_valid = 1'b0;
    in_data = '0; out_ready = 1'b1; clr_ovr = 1'b0;
    tick(); tick();
    rst = 1'b0;
    check("rst_valid", 32'(out_valid), 0);
    check("rst_data", 32'(out_data), 0);
    check("rst_ovr", 32'(overrun), 0);

    // Passthrough, L=0
    start(3'd0);
    exp_q.push_back(8'h12); send(8'h12);
    check("pt0_valid", 32'(out_valid), 1);
    check("pt0_data", 32'(out_data), 32'h12);
    exp_q.push_back(8'hFE); send(8'hFE);
    check("pt1_valid", 32'(out_valid), 1);
    check("pt1_data", 32'(out_data), 32'hFE);
    tick();
    check("pt_drain", 32'(out_valid), 0);

    // L=2 rounding: 43 -> 11, 2 -> 1
    start(3'd2);
    send(8'd10); send(8'd11); send(8'd11);
    check("avg_early", 32'(out_valid), 0);
    exp_q.push_back(8'd11); send(8'd11);
    check("avg43", 32'(out_data), 11);
    send(8'd0); send(8'd0); send(8'd0);
    exp_q.push_back(8'd1); send(8'd2);
    check("avg2", 32'(out_data), 1);

    // L=4 full-scale, then a back-to-back window
    start(3'd4);
    for (int i = 0; i < 15; i++) send(8'hFF);
    exp_q.push_back(8'hFF); send(8'hFF);
    check("sat_data", 32'(out_data), 32'hFF);
    for (int i = 0; i < 15; i++) send(8'h10);
    exp_q.push_back(8'h10); send(8'h10);
    check("b2b_data", 32'(out_data), 32'h10);
    tick(); tick();

    // Backpressure, L=1
    out_ready = 1'b0;
    start(3'd1);
    send(8'd4);
    exp_q.push_back(8'd5); send(8'd6);
    check("bp_held", 32'(out_data), 5);
    check("bp_ovr0", 32'(overrun), 0);
    send(8'd100); send(8'd100);
    check("bp_ovr1", 32'(overrun), 1);
    check("bp_keep", 32'(out_data), 5);
    send(8'd1);
    clr_ovr = 1'b1; send(8'd1); clr_ovr = 1'b0;
    check("bp_setwins", 32'(overrun), 1);
    clr_ovr = 1'b1; tick(); clr_ovr = 1'b0;
    check("bp_clr", 32'(overrun), 0);
    out_ready = 1'b1; tick();
    check("bp_drain", 32'(out_valid), 0);

    // Abort after 3 of 8, then a full window of 0x40
    start(3'd3);
    send(8'h40); send(8'h40); send(8'h40);
    en = 1'b0; tick(); tick();
    check("abort_none", 32'(out_valid), 0);
    en = 1'b1; tick();
    for (int i = 0; i < 7; i++) send(8'h40);
    check("abort_early", 32'(out_valid), 0);
    exp_q.push_back(8'h40); send(8'h40);
    check("abort_word", 32'(out_data), 32'h40);

    // avg_log2 change mid-window takes effect on the next window
    send(8'd8); send(8'd8);
    avg_log2 = 3'd1;
    for (int i = 0; i < 5; i++) send(8'd8);
    check("recfg_early", 32'(out_valid), 0);
    exp_q.push_back(8'd8); send(8'd8);
    check("recfg_old", 32'(out_data), 8);
    send(8'd2);
    exp_q.push_back(8'd3); send(8'd3);
    check("recfg_new", 32'(out_data), 3);

    // Reset with a pending word and cnt=5
    tick();
    out_ready = 1'b0;
    start(3'd3);
    for (int i = 0; i < 8; i++) send(8'h20);
    for (int i = 0; i < 5; i++) send(8'h20);
    check("pre_rst_valid", 32'(out_valid), 1);
    rst = 1'b1; tick(); rst = 1'b0;
    check("mrst_valid", 32'(out_valid), 0);
    check("mrst_data", 32'(out_data), 0);
    check("mrst_ovr", 32'(overrun), 0);
    out_ready = 1'b1;
    tick();
    for (int i = 0; i < 7; i++) send(8'h30);
    check("mrst_early", 32'(out_valid), 0);
    exp_q.push_back(8'h30); send(8'h30);
    check("mrst_word", 32'(out_data), 32'h30);

    tick(); tick();
    check("sb_drain", 32'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
